parking_zone_ctrl: RTL and testbench

- Synchronous, parametrised successor to the event-driven parking counter.
- Manages a car park with TOTAL_SPACE bays split into a university zone and a public zone; the split shifts hour by hour.
- Entry and exit events arrive as valid/ready transactions. Each entry gets a registered grant/reject response.
- University cars displaced by a capacity shift are tracked as overflow in the public zone, so every exit is accounted for exactly.

---
 rtl/parking_zone_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_parking_zone_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/parking_zone_ctrl.sv
// Two-zone car park controller: hourly university/public capacity split, valid/ready entry and exit
// events, overflow tracking of displaced university cars. Optional PARKING_PEAK_STATS_EN adds peak/reject stats.
module parking_zone_ctrl #(
  parameter int TOTAL_SPACE = 700,
  parameter int UNI_MAX     = 500,
  parameter int UNI_MIN     = 200,
  parameter int STEP        = 50,
  parameter int OPEN_HOUR   = 8,
  parameter int SHIFT_START = 13,
  parameter int SHIFT_END   = 16,
  parameter int CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       current_hour,
  input  logic             entry_valid,
  input  logic             entry_is_uni,
  output logic             entry_ready,
  input  logic             exit_valid,
  input  logic             exit_is_uni,
  output logic             exit_ready,
  output logic             entry_grant,
  output logic             entry_reject,
  output logic             entry_pool,
  output logic             exit_err,
  output logic [CNT_W-1:0] uni_occ,
  output logic [CNT_W-1:0] pub_occ,
  output logic [CNT_W-1:0] uni_cap,
  output logic [CNT_W-1:0] pub_cap,
  output logic [CNT_W-1:0] uni_free,
  output logic [CNT_W-1:0] pub_free,
  output logic             uni_full,
  output logic             pub_full
`ifdef PARKING_PEAK_STATS_EN
  ,
  output logic [CNT_W-1:0] peak_occ,
  output logic [15:0]      reject_cnt
`endif
);

  localparam int CW = CNT_W + 4;
  localparam logic [CW-1:0]    W_OPEN  = CW'(OPEN_HOUR);
  localparam logic [CW-1:0]    W_SSTRT = CW'(SHIFT_START);
  localparam logic [CW-1:0]    W_SEND  = CW'(SHIFT_END);
  localparam logic [CW-1:0]    W_LAST  = CW'(23);
  localparam logic [CW-1:0]    W_ONE   = CW'(1);
  localparam logic [CW-1:0]    W_STEP  = CW'(STEP);
  localparam logic [CW-1:0]    W_MAX   = CW'(UNI_MAX);
  localparam logic [CW-1:0]    W_MIN   = CW'(UNI_MIN);
  localparam logic [CNT_W-1:0] TOT     = CNT_W'(TOTAL_SPACE);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  typedef enum logic [1:0] {CLOSED, OPEN, REBAL} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] uni_cnt_q, uni_cnt_d, ovf_cnt_q, ovf_cnt_d, pub_cnt_q, pub_cnt_d;
  logic [CNT_W-1:0] uni_cap_q;
  logic             grant_q, grant_d, reject_q, reject_d, pool_q, pool_d, err_q, err_d;
  logic             hour_open, ready_w, over_w, entry_acc, exit_acc;
  logic [CNT_W:0]   pocc_x, pcap_x, tot_x;
  logic [CNT_W-1:0] pub_cap_w, pub_occ_w;

  function automatic logic [CNT_W-1:0] cap_for_hour(input logic [4:0] hr);
    logic [CW-1:0] h, dec, val;
    h   = CW'(hr);
    dec = '0;
    val = W_MAX;
    if (h >= W_OPEN && h <= W_LAST) begin
      if (h >= W_SEND) begin
        val = W_MIN;
      end else if (h >= W_SSTRT) begin
        dec = (h - W_SSTRT + W_ONE) * W_STEP;
        val = (dec >= W_MAX - W_MIN) ? W_MIN : W_MAX - dec;
      end
    end
    return val[CNT_W-1:0];
  endfunction

  assign hour_open = (current_hour >= 5'(OPEN_HOUR)) && (current_hour <= 5'd23);
  assign over_w    = uni_cnt_q > uni_cap_q;
  // A pending cap drop blocks events until the displaced cars have been moved to overflow.
  assign ready_w   = rst_n && (state_q != REBAL) && !over_w;
  assign entry_acc = entry_valid && ready_w;
  assign exit_acc  = exit_valid && ready_w;

  always_comb begin
    state_d   = state_q;
    uni_cnt_d = uni_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    pub_cnt_d = pub_cnt_q;
    grant_d   = 1'b0;
    reject_d  = 1'b0;
    pool_d    = 1'b0;
    err_d     = 1'b0;
    pocc_x    = '0;
    pcap_x    = '0;
    tot_x     = '0;
    case (state_q)
      CLOSED:  if (hour_open) state_d = OPEN;
      OPEN: begin
        if (over_w)          state_d = REBAL;
        else if (!hour_open) state_d = CLOSED;
      end
      REBAL:   state_d = hour_open ? OPEN : CLOSED;
      default: state_d = CLOSED;
    endcase
    if (state_q == REBAL) begin
      if (over_w) begin
        ovf_cnt_d = ovf_cnt_q + (uni_cnt_q - uni_cap_q);
        uni_cnt_d = uni_cap_q;
      end
    end else begin
      if (exit_acc) begin
        if (exit_is_uni) begin
          if (uni_cnt_q != '0)      uni_cnt_d = uni_cnt_q - ONE;
          else if (ovf_cnt_q != '0) ovf_cnt_d = ovf_cnt_q - ONE;
          else                      err_d = 1'b1;
        end else begin
          if (pub_cnt_q != '0) pub_cnt_d = pub_cnt_q - ONE;
          else                 err_d = 1'b1;
        end
      end
      // Entry sees the post-exit counts; the total guard keeps the lot within TOTAL_SPACE
      // even when a cap rise leaves the public zone over its capacity.
      pocc_x = {1'b0, pub_cnt_d} + {1'b0, ovf_cnt_d};
      pcap_x = {1'b0, pub_cap_w};
      tot_x  = pocc_x + {1'b0, uni_cnt_d};
      if (entry_acc) begin
        if (state_q == CLOSED || tot_x >= {1'b0, TOT}) begin
          reject_d = 1'b1;
        end else if (entry_is_uni && uni_cnt_d < uni_cap_q) begin
          uni_cnt_d = uni_cnt_d + ONE;
          grant_d   = 1'b1;
        end else if (pocc_x < pcap_x) begin
          if (entry_is_uni) ovf_cnt_d = ovf_cnt_d + ONE;
          else              pub_cnt_d = pub_cnt_d + ONE;
          grant_d = 1'b1;
          pool_d  = 1'b1;
        end else begin
          reject_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= CLOSED;
      uni_cnt_q <= '0;
      ovf_cnt_q <= '0;
      pub_cnt_q <= '0;
      uni_cap_q <= CNT_W'(UNI_MAX);
      grant_q   <= 1'b0;
      reject_q  <= 1'b0;
      pool_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      uni_cnt_q <= uni_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
      pub_cnt_q <= pub_cnt_d;
      uni_cap_q <= cap_for_hour(current_hour);
      grant_q   <= grant_d;
      reject_q  <= reject_d;
      pool_q    <= pool_d;
      err_q     <= err_d;
    end
  end

  assign pub_cap_w    = TOT - uni_cap_q;
  assign pub_occ_w    = pub_cnt_q + ovf_cnt_q;
  assign entry_ready  = ready_w;
  assign exit_ready   = ready_w;
  assign entry_grant  = grant_q;
  assign entry_reject = reject_q;
  assign entry_pool   = pool_q;
  assign exit_err     = err_q;
  assign uni_occ      = uni_cnt_q;
  assign pub_occ      = pub_occ_w;
  assign uni_cap      = uni_cap_q;
  assign pub_cap      = pub_cap_w;
  assign uni_free     = over_w ? '0 : uni_cap_q - uni_cnt_q;
  assign pub_free     = (pub_occ_w < pub_cap_w) ? pub_cap_w - pub_occ_w : '0;
  assign uni_full     = (uni_free == '0);
  assign pub_full     = (pub_free == '0);

`ifdef PARKING_PEAK_STATS_EN
  logic [CNT_W-1:0] peak_q;
  logic [15:0]      rej_q;
  logic [CNT_W:0]   tot_d;

  assign tot_d = {1'b0, uni_cnt_d} + {1'b0, ovf_cnt_d} + {1'b0, pub_cnt_d};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_q <= '0;
      rej_q  <= '0;
    end else begin
      if (tot_d[CNT_W-1:0] > peak_q) peak_q <= tot_d[CNT_W-1:0];
      if (reject_d && rej_q != 16'hFFFF) rej_q <= rej_q + 16'd1;
    end
  end

  assign peak_occ   = peak_q;
  assign reject_cnt = rej_q;
`endif

endmodule

// File: tb/tb_parking_zone_ctrl.sv
// Directed bench: dut_a uses default parameters, dut_b a tiny 6-bay lot; both share the stimulus.
module tb_parking_zone_ctrl;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] hour;
  logic       ev, eu, xv, xu;

  logic       a_er, a_xr, a_g, a_rj, a_pl, a_err, a_uf, a_pf;
  logic [9:0] a_uo, a_po, a_uc, a_pc, a_ufr, a_pfr;
  logic       b_er, b_xr, b_g, b_rj, b_pl, b_err, b_uf, b_pf;
  logic [9:0] b_uo, b_po, b_uc, b_pc, b_ufr, b_pfr;
`ifdef PARKING_PEAK_STATS_EN
  logic [9:0]  a_pk, b_pk;
  logic [15:0] a_rc, b_rc;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parking_zone_ctrl dut_a (
    .clk(clk), .rst_n(rst_n), .current_hour(hour),
    .entry_valid(ev), .entry_is_uni(eu), .entry_ready(a_er),
    .exit_valid(xv), .exit_is_uni(xu), .exit_ready(a_xr),
    .entry_grant(a_g), .entry_reject(a_rj), .entry_pool(a_pl), .exit_err(a_err),
    .uni_occ(a_uo), .pub_occ(a_po), .uni_cap(a_uc), .pub_cap(a_pc),
    .uni_free(a_ufr), .pub_free(a_pfr), .uni_full(a_uf), .pub_full(a_pf)
`ifdef PARKING_PEAK_STATS_EN
    , .peak_occ(a_pk), .reject_cnt(a_rc)
`endif
  );

  parking_zone_ctrl #(.TOTAL_SPACE(6), .UNI_MAX(4), .UNI_MIN(1), .STEP(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .current_hour(hour),
    .entry_valid(ev), .entry_is_uni(eu), .entry_ready(b_er),
    .exit_valid(xv), .exit_is_uni(xu), .exit_ready(b_xr),
    .entry_grant(b_g), .entry_reject(b_rj), .entry_pool(b_pl), .exit_err(b_err),
    .uni_occ(b_uo), .pub_occ(b_po), .uni_cap(b_uc), .pub_cap(b_pc),
    .uni_free(b_ufr), .pub_free(b_pfr), .uni_full(b_uf), .pub_full(b_pf)
`ifdef PARKING_PEAK_STATS_EN
    , .peak_occ(b_pk), .reject_cnt(b_rc)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_entry(input logic u);
    ev = 1'b1; eu = u; step(); ev = 1'b0;
  endtask

  task automatic push_exit(input logic u);
    xv = 1'b1; xu = u; step(); xv = 1'b0;
  endtask

  task automatic do_reset(input logic [4:0] hr);
    rst_n = 1'b0; hour = hr; ev = 1'b0; xv = 1'b0; eu = 1'b0; xu = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; hour = 5'd5; ev = 1'b0; xv = 1'b0; eu = 1'b0; xu = 1'b0;
    step(); step();
    total++; if (a_er !== 1'b0) begin bad++; $display("FAIL rst_entry_ready got %0b exp 0", a_er); end
    total++; if (a_xr !== 1'b0) begin bad++; $display("FAIL rst_exit_ready got %0b exp 0", a_xr); end
    total++; if (a_uc !== 10'd500) begin bad++; $display("FAIL rst_uni_cap got %0d exp 500", a_uc); end
    total++; if (a_pc !== 10'd200) begin bad++; $display("FAIL rst_pub_cap got %0d exp 200", a_pc); end
    total++; if (a_uo !== 10'd0 || a_po !== 10'd0) begin bad++; $display("FAIL rst_occ got %0d/%0d exp 0/0", a_uo, a_po); end
    total++; if (a_g !== 1'b0 || a_rj !== 1'b0 || a_err !== 1'b0) begin bad++; $display("FAIL rst_pulses got %0b%0b%0b exp 000", a_g, a_rj, a_err); end
    rst_n = 1'b1;
    step();
    push_entry(1'b1);
    total++; if (a_rj !== 1'b1 || a_g !== 1'b0) begin bad++; $display("FAIL closed_reject got rj=%0b g=%0b exp rj=1 g=0", a_rj, a_g); end
    step();
    total++; if (a_rj !== 1'b0) begin bad++; $display("FAIL reject_pulse_width got %0b exp 0", a_rj); end
    total++; if (a_uo !== 10'd0) begin bad++; $display("FAIL closed_uni_occ got %0d exp 0", a_uo); end
  endtask

  task automatic test_open();
    hour = 5'd9;
    step();
    for (int i = 0; i < 3; i++) begin
      push_entry(1'b1);
      total++; if (a_g !== 1'b1 || a_pl !== 1'b0) begin bad++; $display("FAIL uni_grant%0d got g=%0b pool=%0b exp 1/0", i, a_g, a_pl); end
    end
    for (int i = 0; i < 2; i++) begin
      push_entry(1'b0);
      total++; if (a_g !== 1'b1 || a_pl !== 1'b1) begin bad++; $display("FAIL pub_grant%0d got g=%0b pool=%0b exp 1/1", i, a_g, a_pl); end
    end
    step();
    total++; if (a_uo !== 10'd3) begin bad++; $display("FAIL open_uni_occ got %0d exp 3", a_uo); end
    total++; if (a_po !== 10'd2) begin bad++; $display("FAIL open_pub_occ got %0d exp 2", a_po); end
    total++; if (a_ufr !== 10'd497) begin bad++; $display("FAIL open_uni_free got %0d exp 497", a_ufr); end
    total++; if (a_pfr !== 10'd198) begin bad++; $display("FAIL open_pub_free got %0d exp 198", a_pfr); end
    total++; if (a_g !== 1'b0) begin bad++; $display("FAIL grant_pulse_width got %0b exp 0", a_g); end
  endtask

  task automatic test_caps();
    logic [4:0] hrs [6];
    logic [9:0] caps [6];
    hrs  = '{5'd13, 5'd15, 5'd16, 5'd23, 5'd24, 5'd7};
    caps = '{10'd450, 10'd350, 10'd200, 10'd200, 10'd500, 10'd500};
    for (int i = 0; i < 6; i++) begin
      hour = hrs[i];
      step();
      total++; if (a_uc !== caps[i]) begin bad++; $display("FAIL cap_uni_h%0d got %0d exp %0d", hrs[i], a_uc, caps[i]); end
      total++; if (a_pc !== 10'd700 - caps[i]) begin bad++; $display("FAIL cap_pub_h%0d got %0d exp %0d", hrs[i], a_pc, 10'd700 - caps[i]); end
    end
    push_entry(1'b0);
    total++; if (a_rj !== 1'b1) begin bad++; $display("FAIL early_closed_reject got %0b exp 1", a_rj); end
  endtask

  task automatic test_rebal();
    do_reset(5'd9);
    for (int i = 0; i < 4; i++) push_entry(1'b1);
    total++; if (b_uo !== 10'd4 || b_uf !== 1'b1 || b_ufr !== 10'd0) begin bad++; $display("FAIL fill_uni got occ=%0d full=%0b free=%0d exp 4/1/0", b_uo, b_uf, b_ufr); end
    hour = 5'd13;
    step();
    total++; if (b_er !== 1'b0 || b_xr !== 1'b0) begin bad++; $display("FAIL detect_ready got %0b%0b exp 00", b_er, b_xr); end
    step();
    total++; if (b_er !== 1'b0) begin bad++; $display("FAIL rebal_ready got %0b exp 0", b_er); end
    step();
    total++; if (b_er !== 1'b1) begin bad++; $display("FAIL post_rebal_ready got %0b exp 1", b_er); end
    total++; if (b_uo !== 10'd3 || b_po !== 10'd1) begin bad++; $display("FAIL rebal_occ got %0d/%0d exp 3/1", b_uo, b_po); end
    total++; if (b_uc !== 10'd3 || b_pc !== 10'd3) begin bad++; $display("FAIL rebal_caps got %0d/%0d exp 3/3", b_uc, b_pc); end
    total++; if (b_pfr !== 10'd2) begin bad++; $display("FAIL rebal_pub_free got %0d exp 2", b_pfr); end
  endtask

  task automatic test_simul();
    do_reset(5'd9);
    for (int i = 0; i < 4; i++) push_entry(1'b1);
    for (int i = 0; i < 2; i++) push_entry(1'b0);
    total++; if (b_uf !== 1'b1 || b_pf !== 1'b1) begin bad++; $display("FAIL all_full got %0b%0b exp 11", b_uf, b_pf); end
    ev = 1'b1; eu = 1'b1; xv = 1'b1; xu = 1'b1;
    step();
    ev = 1'b0; xv = 1'b0;
    total++; if (b_g !== 1'b1 || b_pl !== 1'b0 || b_err !== 1'b0) begin bad++; $display("FAIL simul_resp got g=%0b pool=%0b err=%0b exp 1/0/0", b_g, b_pl, b_err); end
    total++; if (b_uo !== 10'd4 || b_po !== 10'd2) begin bad++; $display("FAIL simul_occ got %0d/%0d exp 4/2", b_uo, b_po); end
    push_entry(1'b0);
    total++; if (b_rj !== 1'b1 || b_po !== 10'd2) begin bad++; $display("FAIL full_pub_reject got rj=%0b occ=%0d exp 1/2", b_rj, b_po); end
    push_entry(1'b1);
    total++; if (b_rj !== 1'b1 || b_uo !== 10'd4) begin bad++; $display("FAIL full_uni_reject got rj=%0b occ=%0d exp 1/4", b_rj, b_uo); end
  endtask

  task automatic test_exit();
    do_reset(5'd9);
    push_exit(1'b0);
    total++; if (b_err !== 1'b1 || b_po !== 10'd0 || b_uo !== 10'd0) begin bad++; $display("FAIL empty_pub_exit got err=%0b occ=%0d/%0d exp 1/0/0", b_err, b_uo, b_po); end
    step();
    total++; if (b_err !== 1'b0) begin bad++; $display("FAIL err_pulse_width got %0b exp 0", b_err); end
    for (int i = 0; i < 4; i++) push_entry(1'b1);
    push_entry(1'b1);
    total++; if (b_g !== 1'b1 || b_pl !== 1'b1 || b_po !== 10'd1) begin bad++; $display("FAIL ovf_entry got g=%0b pool=%0b pocc=%0d exp 1/1/1", b_g, b_pl, b_po); end
    for (int i = 0; i < 4; i++) push_exit(1'b1);
    total++; if (b_uo !== 10'd0 || b_po !== 10'd1) begin bad++; $display("FAIL uni_drain got %0d/%0d exp 0/1", b_uo, b_po); end
    push_exit(1'b1);
    total++; if (b_err !== 1'b0 || b_po !== 10'd0) begin bad++; $display("FAIL ovf_exit got err=%0b pocc=%0d exp 0/0", b_err, b_po); end
    push_exit(1'b1);
    total++; if (b_err !== 1'b1) begin bad++; $display("FAIL empty_uni_exit got %0b exp 1", b_err); end
  endtask

`ifdef PARKING_PEAK_STATS_EN
  task automatic test_peak();
    do_reset(5'd9);
    total++; if (b_pk !== 10'd0 || b_rc !== 16'd0) begin bad++; $display("FAIL stats_reset got %0d/%0d exp 0/0", b_pk, b_rc); end
    for (int i = 0; i < 4; i++) push_entry(1'b1);
    for (int i = 0; i < 2; i++) push_entry(1'b0);
    push_entry(1'b0);
    push_exit(1'b0);
    push_exit(1'b0);
    total++; if (b_pk !== 10'd6) begin bad++; $display("FAIL peak_occ got %0d exp 6", b_pk); end
    total++; if (b_rc !== 16'd1) begin bad++; $display("FAIL reject_cnt got %0d exp 1", b_rc); end
    total++; if (b_po !== 10'd0) begin bad++; $display("FAIL peak_pub_occ got %0d exp 0", b_po); end
  endtask
`endif

  initial begin
    test_reset();
    test_open();
    test_caps();
    test_rebal();
    test_simul();
    test_exit();
`ifdef PARKING_PEAK_STATS_EN
    test_peak();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
